// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fnd_pkg
// Description : Shared constants for the HH:MM 7-segment scan driver:
//               blank/dash patterns, anode-off value, digit slot indices,
//               snapshot reset time (12:00) and the BCD-to-segment table.
// Revision    : 1.0 - initial release
// ============================================================================
package fnd_pkg;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // All four anodes released (active-low)
  localparam logic [3:0] AN_OFF = 4'hF;

  // Digit slot indices; an[i] drives slot i
  localparam logic [1:0] IDX_MIN_UNITS = 2'd0;
  localparam logic [1:0] IDX_MIN_TENS  = 2'd1;
  localparam logic [1:0] IDX_HR_UNITS  = 2'd2;
  localparam logic [1:0] IDX_HR_TENS   = 2'd3;

  // Snapshot value out of reset matches the hour counter's reset time 12:00
  localparam logic [3:0] SNAP_RST_HR_TENS   = 4'd1;
  localparam logic [3:0] SNAP_RST_HR_UNITS  = 4'd2;
  localparam logic [3:0] SNAP_RST_MIN_TENS  = 4'd0;
  localparam logic [3:0] SNAP_RST_MIN_UNITS = 4'd0;

  // Digit-pattern table; anything outside 0..9 shows a dash
  function automatic logic [6:0] seg7_lookup(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
// ============================================================================
// Module      : bcd_to_seg7
// Description : Combinational BCD digit to active-low 7-segment pattern.
//               Non-BCD codes (>9) produce a dash (segment g only).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
  import fnd_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  assign o_seg = seg7_lookup(i_bcd);

endmodule
`default_nettype wire

// File: rtl/fnd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : fnd_scan_driver
// Description : 4-digit common-anode 7-segment scan driver for HH:MM.
//               Snapshots the BCD time once per frame (no torn digits),
//               decodes the active slot and drives registered anodes,
//               segments and colon dot with a dead-time blank per slot.
//               Build option FND_COLON_BLINK_EN: colon toggles on each
//               sec_tick; without it the colon is steadily lit.
// Revision    : 1.0 - initial release
// ============================================================================
module fnd_scan_driver
  import fnd_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hr_tens,
  input  logic [3:0] hr_units,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_units,
  input  logic       sec_tick,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int                  c_pc_w      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_pc_w-1:0]   c_pc_last   = c_pc_w'(SCAN_DIV - 1);
  localparam logic [c_pc_w-1:0]   c_blank_end = c_pc_w'(BLANK_CYC);

  logic [c_pc_w-1:0] r_pc;
  logic [1:0]        r_idx;
  logic [3:0]        r_snap_hr_tens;
  logic [3:0]        r_snap_hr_units;
  logic [3:0]        r_snap_min_tens;
  logic [3:0]        r_snap_min_units;
  logic [3:0]        r_an;
  logic [6:0]        r_seg;
  logic              r_dp;

  logic              w_slot_end;
  logic              w_frame_end;
  logic              w_dead;
  logic              w_colon_lit;
  logic [3:0]        w_digit;
  logic [6:0]        w_digit_seg;
  logic [3:0]        w_an_nxt;
  logic [6:0]        w_seg_nxt;
  logic              w_dp_nxt;

  assign w_slot_end  = (r_pc == c_pc_last);
  assign w_frame_end = w_slot_end && (r_idx == IDX_HR_TENS);
  assign w_dead      = (r_pc < c_blank_end);

  // Slot prescaler and digit index; the index advances on the last cycle of a slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= '0;
      r_idx <= IDX_MIN_UNITS;
    end else if (w_slot_end) begin
      r_pc  <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_pc  <= r_pc + 1'b1;
    end
  end

  // Latch the whole time at the end of the hr_tens slot so a frame never mixes old and new digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_hr_tens   <= SNAP_RST_HR_TENS;
      r_snap_hr_units  <= SNAP_RST_HR_UNITS;
      r_snap_min_tens  <= SNAP_RST_MIN_TENS;
      r_snap_min_units <= SNAP_RST_MIN_UNITS;
    end else if (w_frame_end) begin
      r_snap_hr_tens   <= hr_tens;
      r_snap_hr_units  <= hr_units;
      r_snap_min_tens  <= min_tens;
      r_snap_min_units <= min_units;
    end
  end

`ifdef FND_COLON_BLINK_EN
  logic r_blink;

  // Colon blink flag, starts lit and flips once per second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink <= 1'b1;
    end else if (sec_tick) begin
      r_blink <= ~r_blink;
    end
  end

  assign w_colon_lit = r_blink;
`else
  logic w_unused_sec_tick;

  assign w_unused_sec_tick = sec_tick;
  assign w_colon_lit       = 1'b1;
`endif

  // Select the snapshot digit for the active slot
  always_comb begin
    w_digit = r_snap_min_units;
    case (r_idx)
      IDX_MIN_UNITS: w_digit = r_snap_min_units;
      IDX_MIN_TENS:  w_digit = r_snap_min_tens;
      IDX_HR_UNITS:  w_digit = r_snap_hr_units;
      IDX_HR_TENS:   w_digit = r_snap_hr_tens;
      default:       w_digit = r_snap_min_units;
    endcase
  end

  bcd_to_seg7 u_bcd_to_seg7 (
    .i_bcd (w_digit),
    .o_seg (w_digit_seg)
  );

  // Next output values: dead time blanks everything, hour-tens zero is suppressed
  always_comb begin
    w_an_nxt  = AN_OFF;
    w_seg_nxt = SEG_BLANK;
    w_dp_nxt  = 1'b1;
    if (!w_dead) begin
      w_an_nxt = ~(4'b0001 << r_idx);
      if ((r_idx == IDX_HR_TENS) && (r_snap_hr_tens == 4'd0)) begin
        w_seg_nxt = SEG_BLANK;
      end else begin
        w_seg_nxt = w_digit_seg;
      end
      w_dp_nxt = !((r_idx == IDX_HR_UNITS) && w_colon_lit);
    end
  end

  // Registered pad outputs, one cycle behind the scan state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
      r_dp  <= w_dp_nxt;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_fnd_scan_driver
// Description : Self-checking bench for fnd_scan_driver (SCAN_DIV=4,
//               BLANK_CYC=1) against a time-indexed reference model.
//               Honours FND_COLON_BLINK_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_driver;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] hr_tens = 4'd1;
  logic [3:0] hr_units = 4'd2;
  logic [3:0] min_tens = 4'd0;
  logic [3:0] min_units = 4'd0;
  logic       sec_tick = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_checks = 0;
  int n_errors = 0;

  fnd_scan_driver #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hr_tens   (hr_tens),
    .hr_units  (hr_units),
    .min_tens  (min_tens),
    .min_units (min_units),
    .sec_tick  (sec_tick),
    .an        (an),
    .seg       (seg),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time t counts clocks since reset release; slot = (t/SCAN_DIV)%4,
  // phase = t%SCAN_DIV. Displayed digits come from the frame snapshot.
  int         t = 0;
  int         snap [4] = '{0, 0, 2, 1};   // [0]=min_units .. [3]=hr_tens
  bit         blink = 1'b1;
  logic [3:0] exp_an = 4'hF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp = 1'b1;
  logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t       = 0;
      snap    = '{0, 0, 2, 1};
      blink   = 1'b1;
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
    end else begin
      int slot;
      int ph;
      bit colon;
      slot = (t / SCAN_DIV) % 4;
      ph   = t % SCAN_DIV;
`ifdef FND_COLON_BLINK_EN
      colon = blink;
`else
      colon = 1'b1;
`endif
      if (ph < BLANK_CYC) begin
        exp_an  = 4'hF;
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end else begin
        exp_an  = 4'hF;
        exp_an[slot] = 1'b0;
        exp_seg = (slot == 3 && snap[3] == 0) ? 7'h7F : pat[snap[slot]];
        exp_dp  = !(slot == 2 && colon);
      end
      if (ph == SCAN_DIV - 1 && slot == 3)
        snap = '{int'(min_units), int'(min_tens), int'(hr_units), int'(hr_tens)};
      if (sec_tick) blink = !blink;
      t++;
    end
  end

  // Compare every cycle away from the active edge
  always @(negedge clk) begin
    check_val("an", an, exp_an);
    check_val("seg", seg, exp_seg);
    check_val("dp", dp, exp_dp);
    check_val("one_anode", ($countones(~an) <= 1), 1);
  end

  // ---------------- stimulus ----------------
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_time(input int ht, input int hu, input int mt, input int mu);
    @(negedge clk);
    hr_tens   = 4'(ht);
    hr_units  = 4'(hu);
    min_tens  = 4'(mt);
    min_units = 4'(mu);
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    sec_tick = 1'b1;
    @(negedge clk);
    sec_tick = 1'b0;
  endtask

  initial begin
    bit seen;
    // Reset with 12:00 on the inputs
    run(3);
    check_val("rst_an", an, 4'hF);
    check_val("rst_seg", seg, 7'h7F);
    check_val("rst_dp", dp, 1'b1);
    rst_n = 1'b1;
    run(40);

    // 09:45: leading zero blank and hour-units 9
    set_time(0, 9, 4, 5);
    run(40);

    // Minute change mid-frame must wait for the next frame
    run(6);
    set_time(0, 9, 4, 5);
    min_units = 4'd5;
    run(6);
    min_units = 4'd6;
    run(40);

    // Non-BCD minute units shows a dash
    set_time(1, 1, 5, 12);
    run(40);

    // Colon blink behaviour
    pulse_tick();
    run(20);
    pulse_tick();
    run(20);

    // Randomised digits and ticks, occasionally with non-BCD codes
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          hr_tens   = 4'($urandom_range(0, 15));
          hr_units  = 4'($urandom_range(0, 15));
          min_tens  = 4'($urandom_range(0, 15));
          min_units = 4'($urandom_range(0, 15));
        end else begin
          hr_tens   = 4'($urandom_range(0, 1));
          hr_units  = 4'($urandom_range(0, 9));
          min_tens  = 4'($urandom_range(0, 5));
          min_units = 4'($urandom_range(0, 9));
        end
      end
      sec_tick = ($urandom_range(0, 5) == 0);
    end
    sec_tick = 1'b0;

    // Asynchronous reset in the middle of an active slot
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (an != 4'hF) seen = 1'b1;
    end
    check_val("active_before_rst", seen, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_an", an, 4'hF);
    check_val("async_rst_seg", seg, 7'h7F);
    check_val("async_rst_dp", dp, 1'b1);
    run(3);
    rst_n = 1'b1;
    run(40);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
